// File: rtl/park_pkg.sv
// Shared definitions for the parking-lot entry controller.
//   - gate FSM state encoding
//   - default lot size / open-window constants
//   - sensor-pair codes shared with the upstream sensor decoder
package park_pkg;

  // Gate FSM states. The encodings are fixed because the sensor decoder and
  // debug tooling read them.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StOpen  = 2'b01,
    StClose = 2'b10
  } gate_state_e;

  localparam int unsigned DefaultCapacity   = 16;
  localparam int unsigned DefaultCntW       = 8;
  localparam int unsigned DefaultOpenCycles = 8;

  // Sensor-pair codes {inner, outer} as produced by the loop detectors.
  localparam logic [1:0] SensClear = 2'b00;
  localparam logic [1:0] SensOuter = 2'b01;
  localparam logic [1:0] SensInner = 2'b10;
  localparam logic [1:0] SensBoth  = 2'b11;

  // Width needed to hold a down-counter that starts at (cycles - 1).
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/park_occ_counter.sv
// Saturating occupancy counter.
//   clk_i, reset_i : clock, synchronous active-high reset
//   inc_i, dec_i   : single-cycle car entered / car left pulses
//   count_o        : current occupancy (registered)
//   full_o/empty_o : decoded from the registered count
//   err_o          : one-cycle pulse after an overflow/underflow attempt
module park_occ_counter
  import park_pkg::*;
#(
  parameter int unsigned CAPACITY = DefaultCapacity,
  parameter int unsigned CNT_W    = DefaultCntW
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CapVal = CNT_W'(CAPACITY);

  logic [CNT_W-1:0] count_d, count_q;
  logic             err_d, err_q;

  // Coincident inc and dec cancel: one car in, one car out.
  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q == CapVal) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (dec_i && !inc_i) begin
      if (count_q == '0) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CapVal);
  assign empty_o = (count_q == '0);
  assign err_o   = err_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry-gate controller and occupancy tracker.
//   clk_i        : clock, all logic on rising edge
//   reset_i      : synchronous active-high reset, overrides all inputs
//   req_i        : driver request at entry (level), sampled only when idle
//   enter_i      : one-cycle pulse, a car completed entry
//   exit_i       : one-cycle pulse, a car completed exit
//   gate_open_o  : barrier open command (registered)
//   count_o      : current occupancy (registered)
//   full_o       : count_o == CAPACITY
//   empty_o      : count_o == 0
//   err_o        : one-cycle pulse after an overflow/underflow attempt
//   tailgate_o   : one-cycle pulse after an entry while the gate was not open
module parking_gate_ctrl
  import park_pkg::*;
#(
  parameter int unsigned CAPACITY    = DefaultCapacity,
  parameter int unsigned CNT_W       = DefaultCntW,
  parameter int unsigned OPEN_CYCLES = DefaultOpenCycles
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_i,
  input  logic             enter_i,
  input  logic             exit_i,
  output logic             gate_open_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o,
  output logic             tailgate_o
);

  localparam int unsigned TimerW = timer_width(OPEN_CYCLES);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(OPEN_CYCLES - 1);

  gate_state_e       state_q;
  logic [TimerW-1:0] timer_q;
  logic              gate_open_q;
  logic              tailgate_q;
  logic              full;

  // Sensors are ground truth: every pulse is counted regardless of gate state.
  park_occ_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occ (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (enter_i),
    .dec_i   (exit_i),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty_o),
    .err_o   (err_o)
  );

  // Gate FSM with open-window timer. gate_open_q is set alongside the state
  // transition so it is high exactly while the state is StOpen.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      gate_open_q <= 1'b0;
      tailgate_q  <= 1'b0;
    end else begin
      tailgate_q <= enter_i && (state_q != StOpen);
      unique case (state_q)
        StIdle: begin
          if (req_i && !full) begin
            state_q     <= StOpen;
            timer_q     <= TimerLoad;
            gate_open_q <= 1'b1;
          end
        end
        StOpen: begin
          // A pass or an expired window both close the barrier.
          if (enter_i || (timer_q == '0)) begin
            state_q     <= StClose;
            gate_open_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        StClose: begin
          // One settling cycle; requests are ignored here.
          state_q <= StIdle;
        end
        default: begin
          state_q     <= StIdle;
          gate_open_q <= 1'b0;
        end
      endcase
    end
  end

  assign gate_open_o = gate_open_q;
  assign full_o      = full;
  assign tailgate_o  = tailgate_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: the stimulus process predicts each
// cycle's outputs with a behavioural model and queues them tagged by cycle;
// the monitor compares DUT outputs on the falling edge.
module tb_parking_gate_ctrl;

  localparam int Cap     = 16;
  localparam int CntW    = 8;
  localparam int OpenCyc = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            req;
  logic            enter;
  logic            exit_p;
  logic            gate_open;
  logic [CntW-1:0] count;
  logic            full;
  logic            empty;
  logic            err;
  logic            tailgate;

  parking_gate_ctrl #(
    .CAPACITY    (Cap),
    .CNT_W       (CntW),
    .OPEN_CYCLES (OpenCyc)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req),
    .enter_i     (enter),
    .exit_i      (exit_p),
    .gate_open_o (gate_open),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .err_o       (err),
    .tailgate_o  (tailgate)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    bit          gate;
    int          cnt;
    bit          full;
    bit          empty;
    bit          err;
    bit          tg;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp, input int unsigned c);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, c, act, exp);
    end
  endfunction

  // Monitor: compare every expectation due at the current cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.cyc != cyc) begin
        chk("stale_expectation", int'(cyc), int'(e.cyc), cyc);
      end else begin
        chk("gate_open", int'(gate_open), int'(e.gate), cyc);
        chk("count", int'(count), e.cnt, cyc);
        chk("full", int'(full), int'(e.full), cyc);
        chk("empty", int'(empty), int'(e.empty), cyc);
        chk("err", int'(err), int'(e.err), cyc);
        chk("tailgate", int'(tailgate), int'(e.tg), cyc);
      end
    end
  end

  // Behavioural model: the gate is described by how many open cycles remain
  // (0 = shut) plus a settling flag after it shuts.
  int cars      = 0;
  int open_left = 0;
  bit settling  = 1'b0;

  task automatic step(input bit r, input bit e, input bit x, input bit rs);
    exp_t ex;
    bit   m_err;
    bit   m_tg;
    int   old_cars;
    req    = r;
    enter  = e;
    exit_p = x;
    reset  = rs;
    if (rs) begin
      cars = 0; open_left = 0; settling = 0; m_err = 0; m_tg = 0;
    end else begin
      old_cars = cars;
      m_err = (e && !x && cars == Cap) || (x && !e && cars == 0);
      if (e && !x && cars < Cap) cars = cars + 1;
      if (x && !e && cars > 0) cars = cars - 1;
      m_tg = e && (open_left == 0);
      if (open_left > 0) begin
        if (e || open_left == 1) begin
          open_left = 0;
          settling  = 1;
        end else begin
          open_left = open_left - 1;
        end
      end else if (settling) begin
        settling = 0;
      end else if (r && old_cars < Cap) begin
        open_left = OpenCyc;
      end
    end
    ex.cyc   = cyc + 1;
    ex.gate  = (open_left > 0);
    ex.cnt   = cars;
    ex.full  = (cars == Cap);
    ex.empty = (cars == 0);
    ex.err   = m_err;
    ex.tg    = m_tg;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; enter = 1'b0; exit_p = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Timeout path: one request, nobody passes.
    step(1, 0, 0, 0);
    idle(11);

    // Enter on the third open cycle, request during the settling cycle.
    step(1, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    idle(3);

    // Fill the lot, then request while full and force an overflow entry.
    for (int i = 0; i < Cap - 1; i++) begin
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      idle(2);
    end
    step(1, 0, 0, 0);
    idle(3);
    step(0, 1, 0, 0);
    idle(2);

    // Underflow, then simultaneous enter+exit at count 5.
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    idle(1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    idle(1);

    // Tailgate from idle at count 3.
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    idle(1);
    step(0, 1, 0, 0);
    idle(1);

    // Reset during an open window with 7 cars inside.
    step(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    idle(2);
    step(1, 1, 1, 1);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 149) == 0);
    end
    idle(2);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) chk("scoreboard_drain", sb_q.size(), 0, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
